// File: rtl/apb_arb_pkg.sv
// ----------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and constants for the two-requester APB master.
//   apb_state_t : bus sequencing state (IDLE / SETUP / ACCESS)
//   DEF_ADDR_W  : default APB address width
//   DEF_DATA_W  : default APB data width
//   req_id_t    : identifies which requester owns the in-flight transfer
// ----------------------------------------------------------------------------
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef logic req_id_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// apb_rr_arbiter
// Two-way round-robin arbiter. Produces a one-hot grant while enabled and
// flips its priority pointer to the other requester after every grant.
//   pclk, preset : clock, asynchronous active-high reset
//   valid[1:0]   : request lines from requester 1 / requester 0
//   idle_en      : grants are only issued while this is high
//   grant[1:0]   : one-hot grant, combinational
// ----------------------------------------------------------------------------
module apb_rr_arbiter
   import apb_arb_pkg::*;
(
   input  logic       pclk,
   input  logic       preset,
   input  logic [1:0] valid,
   input  logic       idle_en,
   output logic [1:0] grant
);

   // 0 favours requester 0, 1 favours requester 1 when both are valid
   req_id_t ptr;

   always_comb begin
      grant = 2'b00;
      if (idle_en) begin
         if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
         end else begin
            grant = valid;
         end
      end
   end

   // Any grant is an acceptance, since ready equals grant
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         ptr <= 1'b0;
      end else if (|grant) begin
         ptr <= grant[0];
      end
   end

endmodule

// File: rtl/apb_arb_master.sv
// ----------------------------------------------------------------------------
// apb_arb_master
// APB master shared by two requesters. A round-robin arbiter picks one
// requester in IDLE; the transfer is latched and driven through SETUP and
// ACCESS, then completion (read data / error) is returned to that requester
// as a one-cycle done pulse. ACCESS aborts with an error after TIMEOUT cycles
// without pready (TIMEOUT = 0 waits forever).
//   pclk, preset          : clock, asynchronous active-high reset
//   reqN_valid/ready      : request handshake (ready = grant, IDLE only)
//   reqN_addr/write/wdata : transfer description, held stable while waiting
//   reqN_done             : completion pulse
//   reqN_rdata/err        : completion result, held until the next done
//   paddr..pwdata         : APB master outputs (registered)
//   prdata/pready/pslverr : APB slave response
// ----------------------------------------------------------------------------
module apb_arb_master
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic              req0_write,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic              req1_write,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,

   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   // Counter must be able to hold the value TIMEOUT itself
   localparam int              CNT_W  = $clog2(TIMEOUT + 2);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   apb_state_t        state;
   req_id_t           owner;
   logic [CNT_W-1:0]  wait_cnt;
   logic [1:0]        grant;
   logic              idle_en;

   logic [ADDR_W-1:0] sel_addr;
   logic              sel_write;
   logic [DATA_W-1:0] sel_wdata;
   logic              timed_out;
   logic              acc_end;
   logic              end_err;
   logic [DATA_W-1:0] end_rdata;

   // Holding the grant low during reset keeps ready at 0 while preset is high
   assign idle_en    = (state == IDLE) && !preset;
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   apb_rr_arbiter u_arb (
      .pclk    (pclk),
      .preset  (preset),
      .valid   ({req1_valid, req0_valid}),
      .idle_en (idle_en),
      .grant   (grant)
   );

   always_comb begin
      sel_addr  = grant[1] ? req1_addr  : req0_addr;
      sel_write = grant[1] ? req1_write : req0_write;
      sel_wdata = grant[1] ? req1_wdata : req0_wdata;

      timed_out = (TIMEOUT != 0) && !pready && (wait_cnt == TO_VAL);
      acc_end   = (state == ACCESS) && (pready || timed_out);

      // An abort reports an error with no data; a write never returns data
      end_err   = pready ? pslverr : 1'b1;
      end_rdata = (pready && !pwrite) ? prdata : '0;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         wait_cnt   <= '0;
         paddr      <= '0;
         psel       <= 1'b0;
         penable    <= 1'b0;
         pwrite     <= 1'b0;
         pwdata     <= '0;
         req0_done  <= 1'b0;
         req0_rdata <= '0;
         req0_err   <= 1'b0;
         req1_done  <= 1'b0;
         req1_rdata <= '0;
         req1_err   <= 1'b0;
      end else begin
         req0_done <= 1'b0;
         req1_done <= 1'b0;

         case (state)
            IDLE: begin
               if (|grant) begin
                  owner   <= grant[1];
                  paddr   <= sel_addr;
                  pwrite  <= sel_write;
                  pwdata  <= sel_write ? sel_wdata : '0;
                  psel    <= 1'b1;
                  penable <= 1'b0;
                  state   <= SETUP;
               end
            end

            SETUP: begin
               penable  <= 1'b1;
               wait_cnt <= CNT_W'(1);
               state    <= ACCESS;
            end

            ACCESS: begin
               if (acc_end) begin
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  state   <= IDLE;
                  if (owner) begin
                     req1_done  <= 1'b1;
                     req1_err   <= end_err;
                     req1_rdata <= end_rdata;
                  end else begin
                     req0_done  <= 1'b1;
                     req0_err   <= end_err;
                     req0_rdata <= end_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
